mandelbrot_iter: RTL and testbench

Per-pixel iteration engine for the Mandelbrot renderer. It accepts one complex constant c over a valid/ready handshake and holds the iterate z in registers. Each cycle it steps z through the combinational one-step Mandelbrot ALU until the point escapes, overflows, or reaches the iteration limit. It returns the iteration count to the pixel/colour stage downstream.

---
 rtl/mandelbrot_pkg.sv | 25 ++
 rtl/mandelbrot_alu.sv | 54 +++++
 rtl/mandelbrot_iter.sv | 130 +++++++++++++
 tb/tb_mandelbrot_iter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mandelbrot_pkg.sv
// Shared definitions for the Mandelbrot pixel engine: state encoding, default widths and
// fixed-point helpers.
package mandelbrot_pkg;

    localparam int unsigned DefWidth    = 8;
    localparam int unsigned DefCntWidth = 6;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ITER = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    typedef enum logic [1:0] {
        StIdle = IDLE,
        StIter = ITER,
        StDone = DONE
    } state_e;

    // Fixed-point 1.0 for the default width (format 2.(WIDTH-2)).
    localparam int unsigned ONE = 1 << (DefWidth - 2);

    function automatic int unsigned fx_one(input int unsigned width);
        return 1 << (width - 2);
    endfunction

endpackage

// File: rtl/mandelbrot_alu.sv
// Combinational one-step Mandelbrot ALU: z' = z^2 + c in signed 2.(WIDTH-2) fixed point,
// with escape (|z|^2 > 4) and range-overflow flags.
module mandelbrot_alu
    import mandelbrot_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth
) (
    input  logic signed [WIDTH-1:0] in_cr,
    input  logic signed [WIDTH-1:0] in_ci,
    input  logic signed [WIDTH-1:0] in_zr,
    input  logic signed [WIDTH-1:0] in_zi,
    output logic signed [WIDTH-1:0] out_zr,
    output logic signed [WIDTH-1:0] out_zi,
    output logic                    size,
    output logic                    overflow
);

    localparam int unsigned PW   = 2 * WIDTH + 2;
    localparam int unsigned FRAC = WIDTH - 2;

    // 4.0 expressed with the 2*FRAC fractional bits of a full-precision square.
    localparam logic signed [PW-1:0] MagLimit = PW'(1) << (2 * WIDTH - 2);

    logic signed [PW-1:0] zr_x, zi_x, cr_x, ci_x;
    logic signed [PW-1:0] sq_r, sq_i, x_prod, mag;
    logic signed [PW-1:0] re_full, im_full;
    logic                 ovf_r, ovf_i;

    always_comb begin
        zr_x    = PW'(in_zr);
        zi_x    = PW'(in_zi);
        cr_x    = PW'(in_cr);
        ci_x    = PW'(in_ci);

        sq_r    = zr_x * zr_x;
        sq_i    = zi_x * zi_x;
        x_prod  = zr_x * zi_x;
        mag     = sq_r + sq_i;

        // Products carry 2*FRAC fraction bits; arithmetic shift floors back to FRAC.
        re_full = ((sq_r - sq_i) >>> FRAC) + cr_x;
        im_full = ((x_prod <<< 1) >>> FRAC) + ci_x;

        // In range iff all bits above the WIDTH-bit sign position match the sign.
        ovf_r   = !((&re_full[PW-1:WIDTH-1]) || !(|re_full[PW-1:WIDTH-1]));
        ovf_i   = !((&im_full[PW-1:WIDTH-1]) || !(|im_full[PW-1:WIDTH-1]));

        size     = mag > MagLimit;
        overflow = ovf_r || ovf_i;
        out_zr   = re_full[WIDTH-1:0];
        out_zi   = im_full[WIDTH-1:0];
    end

endmodule

// File: rtl/mandelbrot_iter.sv
// Per-pixel Mandelbrot iteration engine: accepts c, iterates z until escape, overflow or
// the iteration limit, then holds the count until downstream takes it.
module mandelbrot_iter
    import mandelbrot_pkg::*;
#(
    parameter int unsigned WIDTH     = DefWidth,
    parameter int unsigned CNT_WIDTH = DefCntWidth
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_cr,
    input  logic [WIDTH-1:0]     in_ci,
    input  logic [CNT_WIDTH-1:0] in_max_iter,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CNT_WIDTH-1:0] out_iter,
    output logic                 out_escaped,
    output logic                 out_overflow
);

    state_e state_q, state_d;

    logic signed [WIDTH-1:0] zr_q, zr_d, zi_q, zi_d;
    logic signed [WIDTH-1:0] cr_q, cr_d, ci_q, ci_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d, max_q, max_d;
    logic [CNT_WIDTH-1:0]    iter_q, iter_d;
    logic                    esc_q, esc_d, ovf_q, ovf_d;

    logic signed [WIDTH-1:0] alu_zr, alu_zi;
    logic                    alu_size, alu_ovf;

    mandelbrot_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .in_cr    (cr_q),
        .in_ci    (ci_q),
        .in_zr    (zr_q),
        .in_zi    (zi_q),
        .out_zr   (alu_zr),
        .out_zi   (alu_zi),
        .size     (alu_size),
        .overflow (alu_ovf)
    );

    always_comb begin
        state_d = state_q;
        zr_d    = zr_q;
        zi_d    = zi_q;
        cr_d    = cr_q;
        ci_d    = ci_q;
        cnt_d   = cnt_q;
        max_d   = max_q;
        iter_d  = iter_q;
        esc_d   = esc_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    cr_d    = in_cr;
                    ci_d    = in_ci;
                    max_d   = in_max_iter;
                    zr_d    = '0;
                    zi_d    = '0;
                    cnt_d   = '0;
                    state_d = StIter;
                end
            end
            StIter: begin
                // Escape beats the limit; the limit check precedes the increment so cnt never wraps.
                if (alu_size || alu_ovf) begin
                    iter_d  = cnt_q;
                    esc_d   = 1'b1;
                    ovf_d   = alu_ovf;
                    state_d = StDone;
                end else if (cnt_q == max_q) begin
                    iter_d  = cnt_q;
                    esc_d   = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = StDone;
                end else begin
                    zr_d  = alu_zr;
                    zi_d  = alu_zi;
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            zr_q    <= '0;
            zi_q    <= '0;
            cr_q    <= '0;
            ci_q    <= '0;
            cnt_q   <= '0;
            max_q   <= '0;
            iter_q  <= '0;
            esc_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            zr_q    <= zr_d;
            zi_q    <= zi_d;
            cr_q    <= cr_d;
            ci_q    <= ci_d;
            cnt_q   <= cnt_d;
            max_q   <= max_d;
            iter_q  <= iter_d;
            esc_q   <= esc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready     = (state_q == StIdle);
    assign out_valid    = (state_q == StDone);
    assign out_iter     = iter_q;
    assign out_escaped  = esc_q;
    assign out_overflow = ovf_q;

endmodule

// File: tb/tb_mandelbrot_iter.sv
// Scoreboard bench for mandelbrot_iter: expected results are queued at each accepted pixel
// from a plain-arithmetic escape-time model and popped by an independent output monitor.
module tb_mandelbrot_iter;

    localparam int W    = 8;
    localparam int CW   = 6;
    localparam int FRAC = W - 2;
    localparam int ONE  = 1 << FRAC;
    localparam int ZMAX = (1 << (W - 1)) - 1;
    localparam int ZMIN = -(1 << (W - 1));

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_cr = '0;
    logic [W-1:0]  in_ci = '0;
    logic [CW-1:0] in_max_iter = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [CW-1:0] out_iter;
    logic          out_escaped;
    logic          out_overflow;

    mandelbrot_iter #(
        .WIDTH     (W),
        .CNT_WIDTH (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_cr        (in_cr),
        .in_ci        (in_ci),
        .in_max_iter  (in_max_iter),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_iter     (out_iter),
        .out_escaped  (out_escaped),
        .out_overflow (out_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int iter;
        bit esc;
        bit ovf;
        int acc;
        bit dir;
        int d_iter;
        bit d_esc;
        bit d_ovf;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   edge_cnt = 0;
    int   ready_mode = 0;  // 0: always ready, 1: random, 2: held low
    bit   dir_en = 0;
    int   dir_iter = 0;
    bit   dir_esc = 0;
    bit   dir_ovf = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Escape-time reference: z0 = 0, z' = z^2 + c, products floored to the fixed-point grid.
    function automatic void model(input int cr, input int ci, input int mx,
                                  output int it, output bit esc, output bit ovf);
        int zr = 0;
        int zi = 0;
        int nr, ni;
        bit sz;
        it = 0; esc = 0; ovf = 0;
        for (int cnt = 0; cnt <= mx; cnt++) begin
            sz  = (zr * zr + zi * zi) > 4 * ONE * ONE;
            nr  = ((zr * zr - zi * zi) >>> FRAC) + cr;
            ni  = ((2 * zr * zi) >>> FRAC) + ci;
            ovf = (nr > ZMAX) || (nr < ZMIN) || (ni > ZMAX) || (ni < ZMIN);
            if (sz || ovf) begin
                it = cnt; esc = 1; return;
            end
            if (cnt == mx) begin
                it = cnt; ovf = 0; return;
            end
            zr = nr;
            zi = ni;
        end
    endfunction

    // Expectation producer: one entry per accepted pixel.
    always @(posedge clk) begin
        exp_t e;
        edge_cnt++;
        if (!rst && in_valid && in_ready) begin
            model(int'($signed(in_cr)), int'($signed(in_ci)), int'(in_max_iter),
                  e.iter, e.esc, e.ovf);
            e.acc    = edge_cnt;
            e.dir    = dir_en;
            e.d_iter = dir_iter;
            e.d_esc  = dir_esc;
            e.d_ovf  = dir_ovf;
            q.push_back(e);
        end
    end

    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    // Output monitor.
    bit            prev_valid = 0;
    bit            prev_ready = 0;
    logic [CW-1:0] prev_iter;
    logic          prev_esc, prev_ovf;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_valid = 0;
        end else begin
            if (out_valid) begin
                check("in_ready_low_in_done", int'(in_ready), 0);
                if (!prev_valid) begin
                    if (q.size() == 0) begin
                        check("unexpected_result", 1, 0);
                    end else begin
                        e = q.pop_front();
                        check("iter", int'(out_iter), e.iter);
                        check("escaped", int'(out_escaped), int'(e.esc));
                        check("overflow", int'(out_overflow), int'(e.ovf));
                        check("latency", edge_cnt - e.acc, e.iter + 1);
                        if (e.dir) begin
                            check("dir_iter", int'(out_iter), e.d_iter);
                            check("dir_escaped", int'(out_escaped), int'(e.d_esc));
                            check("dir_overflow", int'(out_overflow), int'(e.d_ovf));
                        end
                    end
                end else if (!prev_ready) begin
                    check("stable_iter", int'(out_iter), int'(prev_iter));
                    check("stable_escaped", int'(out_escaped), int'(prev_esc));
                    check("stable_overflow", int'(out_overflow), int'(prev_ovf));
                end
            end
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_iter  = out_iter;
            prev_esc   = out_escaped;
            prev_ovf   = out_overflow;
        end
    end

    // Call at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input int cr, input int ci, input int mx);
        bit acc = 0;
        in_valid    = 1'b1;
        in_cr       = W'(cr);
        in_ci       = W'(ci);
        in_max_iter = CW'(mx);
        for (int i = 0; i < 500 && !acc; i++) begin
            @(posedge clk);
            acc = in_ready;
            #1;
        end
        in_valid = 1'b0;
        if (!acc) check("accept_timeout", 0, 1);
    endtask

    task automatic send_dir(input int cr, input int ci, input int mx,
                            input int it, input bit esc, input bit ovf);
        dir_en = 1; dir_iter = it; dir_esc = esc; dir_ovf = ovf;
        send(cr, ci, mx);
        dir_en = 0;
    endtask

    task automatic drain();
        bit done = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(posedge clk);
            #1;
            done = (q.size() == 0) && in_ready;
        end
        if (!done) check("drain_timeout", 0, 1);
    endtask

    initial begin
        int vcount;
        bit seen;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_iter", int'(out_iter), 0);
        check("rst_out_escaped", int'(out_escaped), 0);
        check("rst_out_overflow", int'(out_overflow), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        send_dir(8'h00, 8'h00, 10, 10, 0, 0);
        drain();
        send_dir(8'h40, 8'h00, 20, 1, 1, 1);
        drain();
        send_dir(8'hC0, 8'h00, 63, 63, 0, 0);
        drain();
        send_dir(8'h95, 8'h7A, 0, 0, 0, 0);
        drain();

        // Back-pressure in DONE.
        ready_mode = 2;
        send(8'h00, 8'h00, 3);
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = out_valid;
        end
        if (!seen) check("bp_valid_timeout", 0, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1; in_cr = 8'h10; in_ci = 8'h20; in_max_iter = 6'd5;
            check("bp_in_ready_low", int'(in_ready), 0);
        end
        check("bp_no_accept", q.size(), 0);
        ready_mode = 0;
        @(posedge clk);
        check("bp_release_edge_ready", int'(in_ready), 0);
        @(posedge clk);
        check("bp_accept_next_cycle", int'(in_ready), 1);
        #1 in_valid = 1'b0;
        check("bp_busy_after_accept", int'(in_ready), 0);
        drain();

        // Reset during ITER discards the pixel.
        send(8'h00, 8'h00, 30);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_in_ready", int'(in_ready), 1);
        check("mid_rst_out_valid", int'(out_valid), 0);
        q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        vcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) vcount++;
        end
        check("no_valid_after_abort", vcount, 0);
        @(posedge clk);
        #1;
        send_dir(8'h00, 8'h00, 4, 4, 0, 0);
        drain();

        // Randomised traffic with random back-pressure.
        ready_mode = 1;
        for (int n = 0; n < 40; n++) begin
            int cr, ci;
            if (n % 2 == 0) begin
                cr = int'($urandom_range(0, 96)) - 48;
                ci = int'($urandom_range(0, 96)) - 48;
            end else begin
                cr = int'($urandom_range(0, 255));
                ci = int'($urandom_range(0, 255));
            end
            send(cr, ci, int'($urandom_range(0, 63)));
        end
        drain();
        ready_mode = 0;
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
